// File: rtl/gold_core_pkg.sv
// rtl/gold_core_pkg.sv - shared Gold core widths, fetch-entry type and buffer states
package gold_core_pkg;

  localparam int ADDR_W  = 9;
  localparam int INSTR_W = 32;

  localparam logic [0:INSTR_W-1] NOP_INSTR = 32'h0000_0013;

  // Carried from fetch into decode so every instruction keeps its own address.
  typedef struct packed {
    logic [0:ADDR_W-1]  pc;
    logic [0:INSTR_W-1] instr;
  } fetchEntry_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } bufState_t;

endpackage

// File: rtl/gold_ifetch_if.sv
// rtl/gold_ifetch_if.sv - fetch-stage bus: memory port, redirect input, decode handshake
interface gold_ifetch_if;
  import gold_core_pkg::*;

  logic                fetch_en;
  logic [0:ADDR_W-1]   imem_addr;
  logic [0:INSTR_W-1]  imem_data;
  logic                redirect_valid;
  logic [0:ADDR_W-1]   redirect_pc;
  logic                out_valid;
  logic                out_ready;
  logic [0:INSTR_W-1]  out_instr;
  logic [0:ADDR_W-1]   out_pc;
  logic [0:1]          buf_count;

  modport master (
    input  fetch_en, imem_data, redirect_valid, redirect_pc, out_ready,
    output imem_addr, out_valid, out_instr, out_pc, buf_count
  );

  modport slave (
    output fetch_en, imem_data, redirect_valid, redirect_pc, out_ready,
    input  imem_addr, out_valid, out_instr, out_pc, buf_count
  );

endinterface

// File: rtl/gold_ibuf.sv
// rtl/gold_ibuf.sv - two-entry instruction buffer with flush and sticky head
module gold_ibuf
  import gold_core_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic        push,
  input  fetchEntry_t pushEntry,
  input  logic        pop,
  input  logic        flush,
  output logic [0:1]  count,
  output fetchEntry_t head
);

  fetchEntry_t slots [2];
  fetchEntry_t lastHead;
  logic        rdPtr;
  logic        wrPtr;
  logic        doPop;
  logic        doPush;
  bufState_t   state;
  bufState_t   nextState;

  assign doPop  = pop & (state != EMPTY);
  assign doPush = push & ~flush & ((state != FULL) | doPop);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= EMPTY;
      rdPtr    <= 1'b0;
      wrPtr    <= 1'b0;
      lastHead <= '0;
      for (int i = 0; i < 2; i++) slots[i] <= '0;
    end else begin
      state <= nextState;
      if (flush) begin
        rdPtr <= 1'b0;
        wrPtr <= 1'b0;
      end else begin
        if (doPop) rdPtr <= ~rdPtr;
        if (doPush) begin
          slots[wrPtr] <= pushEntry;
          wrPtr        <= ~wrPtr;
        end
      end
      // Remember what decode last saw so the outputs hold once the buffer empties.
      if (state != EMPTY) lastHead <= slots[rdPtr];
    end
  end

  always_comb begin
    nextState = state;
    if (flush) begin
      nextState = EMPTY;
    end else begin
      case (state)
        EMPTY:   if (doPush) nextState = ONE;
        ONE:     if (doPush && !doPop) nextState = FULL;
                 else if (!doPush && doPop) nextState = EMPTY;
        FULL:    if (!doPush && doPop) nextState = ONE;
        default: nextState = EMPTY;
      endcase
    end
  end

  assign count = state;
  assign head  = (state != EMPTY) ? slots[rdPtr] : lastHead;

endmodule

// File: rtl/gold_ifetch.sv
// rtl/gold_ifetch.sv - Gold fetch stage: PC, redirect and fetch/pop control around gold_ibuf
module gold_ifetch
  import gold_core_pkg::*;
#(
  parameter logic [0:ADDR_W-1] RESET_PC = '0,
  parameter int                DEPTH    = 2
) (
  input  logic          clk,
  input  logic          reset_n,
  gold_ifetch_if.master bus
);

  localparam logic [0:1] FULL_COUNT = 2'(DEPTH);

  logic [0:ADDR_W-1] pc;
  logic [0:1]        bufCount;
  logic              outValid;
  logic              pop;
  logic              fetch;
  fetchEntry_t       pushEntry;
  fetchEntry_t       head;

  assign outValid = (bufCount != 2'd0);
  // A redirect voids any pop and fetch in the same cycle.
  assign pop   = outValid & bus.out_ready & ~bus.redirect_valid;
  assign fetch = bus.fetch_en & ~bus.redirect_valid & ((bufCount != FULL_COUNT) | pop);

  assign pushEntry = '{pc: pc, instr: bus.imem_data};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc <= RESET_PC;
    end else if (bus.redirect_valid) begin
      pc <= bus.redirect_pc;
    end else if (fetch) begin
      pc <= pc + ADDR_W'(1);
    end
  end

  gold_ibuf u_ibuf (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (fetch),
    .pushEntry (pushEntry),
    .pop       (pop),
    .flush     (bus.redirect_valid),
    .count     (bufCount),
    .head      (head)
  );

  assign bus.imem_addr = pc;
  assign bus.out_valid = outValid;
  assign bus.out_instr = head.instr;
  assign bus.out_pc    = head.pc;
  assign bus.buf_count = bufCount;

endmodule

// File: tb/tb_gold_ifetch.sv
// tb/tb_gold_ifetch.sv - directed vector table plus randomized queue-model check of gold_ifetch
module tb_gold_ifetch;

  typedef struct {
    logic       en;
    logic       rdy;
    logic       rv;
    logic [8:0] rpc;
    logic       expValid;
    logic [1:0] expCount;
    logic [8:0] expAddr;
    logic [8:0] expPc;
  } vec_t;

  typedef struct {
    logic [8:0]  pc;
    logic [31:0] instr;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [31:0] imem [512];
  int          tests = 0;
  int          fails = 0;
  vec_t        vecs[$];
  ent_t        q[$];
  ent_t        lastHead;
  ent_t        hd;
  logic [8:0]  mPc;

  gold_ifetch_if bus();

  gold_ifetch #(.RESET_PC(9'd0), .DEPTH(2)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.master)
  );

  always #5 clk = ~clk;

  always_comb bus.imem_data = imem[bus.imem_addr];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkAll(input string tag, input logic expValid, input logic [1:0] expCount,
                          input logic [8:0] expAddr, input logic [8:0] expPc,
                          input logic [31:0] expInstr);
    check({tag, " out_valid"}, 32'(bus.out_valid), 32'(expValid));
    check({tag, " buf_count"}, 32'(bus.buf_count), 32'(expCount));
    check({tag, " imem_addr"}, 32'(bus.imem_addr), 32'(expAddr));
    check({tag, " out_pc"},    32'(bus.out_pc),    32'(expPc));
    check({tag, " out_instr"}, bus.out_instr,      expInstr);
  endtask

  task automatic addVec(input logic en, input logic rdy, input logic rv, input logic [8:0] rpc,
                        input logic ev, input logic [1:0] ec, input logic [8:0] ea,
                        input logic [8:0] ep);
    vec_t v;
    v.en = en; v.rdy = rdy; v.rv = rv; v.rpc = rpc;
    v.expValid = ev; v.expCount = ec; v.expAddr = ea; v.expPc = ep;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic en, input logic rdy, input logic rv, input logic [8:0] rpc);
    bus.fetch_en       = en;
    bus.out_ready      = rdy;
    bus.redirect_valid = rv;
    bus.redirect_pc    = rpc;
  endtask

  initial begin
    drive(1'b0, 1'b0, 1'b0, 9'd0);
    for (int i = 0; i < 512; i++) imem[i] = $urandom;
    for (int i = 0; i < 8; i++) imem[i] = 32'h1111_1111 * (i + 1);

    // en rdy rv rpc | valid count addr head_pc
    addVec(1, 1, 0, 9'h000, 1, 1, 9'h001, 9'h000);
    addVec(1, 1, 0, 9'h000, 1, 1, 9'h002, 9'h001);
    addVec(1, 1, 0, 9'h000, 1, 1, 9'h003, 9'h002);
    addVec(1, 0, 0, 9'h000, 1, 2, 9'h004, 9'h002);
    addVec(1, 0, 0, 9'h000, 1, 2, 9'h004, 9'h002);
    addVec(1, 0, 0, 9'h000, 1, 2, 9'h004, 9'h002);
    addVec(1, 1, 0, 9'h000, 1, 2, 9'h005, 9'h003);
    addVec(1, 1, 0, 9'h000, 1, 2, 9'h006, 9'h004);
    addVec(1, 1, 1, 9'h1F0, 0, 0, 9'h1F0, 9'h004);
    addVec(1, 0, 0, 9'h000, 1, 1, 9'h1F1, 9'h1F0);
    addVec(1, 0, 0, 9'h000, 1, 2, 9'h1F2, 9'h1F0);
    addVec(0, 1, 0, 9'h000, 1, 1, 9'h1F2, 9'h1F1);
    addVec(0, 1, 0, 9'h000, 0, 0, 9'h1F2, 9'h1F1);
    addVec(0, 1, 0, 9'h000, 0, 0, 9'h1F2, 9'h1F1);
    addVec(1, 1, 0, 9'h000, 1, 1, 9'h1F3, 9'h1F2);
    addVec(1, 1, 1, 9'd510, 0, 0, 9'd510, 9'h1F2);
    addVec(1, 1, 0, 9'h000, 1, 1, 9'd511, 9'd510);
    addVec(1, 1, 0, 9'h000, 1, 1, 9'd0,   9'd511);
    addVec(1, 1, 0, 9'h000, 1, 1, 9'd1,   9'd0);
    addVec(1, 1, 0, 9'h000, 1, 1, 9'd2,   9'd1);
    addVec(0, 0, 1, 9'h0AA, 0, 0, 9'h0AA, 9'd1);
    addVec(0, 0, 0, 9'h000, 0, 0, 9'h0AA, 9'd1);

    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    checkAll("reset", 1'b0, 2'd0, 9'd0, 9'd0, 32'd0);

    foreach (vecs[i]) begin
      drive(vecs[i].en, vecs[i].rdy, vecs[i].rv, vecs[i].rpc);
      @(posedge clk);
      @(negedge clk);
      checkAll($sformatf("vec%0d", i), vecs[i].expValid, vecs[i].expCount,
               vecs[i].expAddr, vecs[i].expPc, imem[vecs[i].expPc]);
    end

    // Fill the buffer, then pull reset between edges.
    drive(1'b1, 1'b0, 1'b0, 9'd0);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    check("fill buf_count", 32'(bus.buf_count), 32'd2);
    check("fill imem_addr", 32'(bus.imem_addr), 32'h0AC);
    #1 reset_n = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 9'd0);
    #1 checkAll("async_reset", 1'b0, 2'd0, 9'd0, 9'd0, 32'd0);
    #1 reset_n = 1'b1;
    @(negedge clk);

    q.delete();
    lastHead = '{pc: 9'd0, instr: 32'd0};
    mPc = 9'd0;
    for (int c = 0; c < 600; c++) begin
      logic       en, rdy, rv, popNow, fetchNow;
      logic [8:0] rpc;
      hd = (q.size() != 0) ? q[0] : lastHead;
      checkAll("rand", q.size() != 0, 2'(q.size()), mPc, hd.pc, hd.instr);

      en  = ($urandom_range(0, 7) != 0);
      rdy = ($urandom_range(0, 2) != 0);
      rv  = ($urandom_range(0, 11) == 0);
      rpc = ($urandom_range(0, 3) == 0) ? 9'(508 + $urandom_range(0, 3)) : 9'($urandom_range(0, 511));
      drive(en, rdy, rv, rpc);
      @(posedge clk);

      if (q.size() != 0) lastHead = q[0];
      if (rv) begin
        q.delete();
        mPc = rpc;
      end else begin
        popNow   = (q.size() != 0) && rdy;
        fetchNow = en && ((q.size() < 2) || popNow);
        if (popNow) void'(q.pop_front());
        if (fetchNow) begin
          q.push_back('{pc: mPc, instr: imem[mPc]});
          mPc = mPc + 9'd1;
        end
      end
      @(negedge clk);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/gold_ifetch.md
Name: gold_ifetch

Overview:
- Instruction-fetch stage of the Gold processor core. It sits directly upstream of the 512x32 asynchronous-read instruction memory and drives that memory's 9-bit word address.
- It owns the PC, captures the combinational read data into a 2-entry instruction buffer tagged with its PC, and presents instructions to decode over a valid/ready handshake.
- It accepts branch/jump redirects from the execute stage.

Parameters:
- ADDR_W, 9: instruction word-address width; matches the memory depth of 512.
- INSTR_W, 32: instruction width.
- RESET_PC, 9'd0: PC value loaded on reset.
- DEPTH, 2: instruction buffer entries. Fixed at 2; any other value is unsupported.

Ports:
- clk  in  1  single core clock; all state is updated on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- fetch_en  in  1  core enable; when low, no new fetch is issued.
- imem_addr  out  [0:ADDR_W-1]  word address to instruction memory; always equals pc.
- imem_data  in  [0:INSTR_W-1]  instruction memory read data; combinational function of imem_addr.
- redirect_valid  in  1  execute stage requests a PC change.
- redirect_pc  in  [0:ADDR_W-1]  redirect target word address.
- out_valid  out  1  buffer head holds a valid instruction.
- out_ready  in  1  decode accepts the head this cycle.
- out_instr  out  [0:INSTR_W-1]  head instruction.
- out_pc  out  [0:ADDR_W-1]  word address of the head instruction.
- buf_count  out  [0:1]  occupancy, 0..2.

Behaviour:
- Reset (asynchronous assert, synchronous-safe deassert):
  - pc=RESET_PC, buf_count=0, out_valid=0, out_instr=0, out_pc=0.
  - Buffer read and write pointers are 0.
  - Asserting reset mid-operation discards all buffered entries immediately.
- Pointers: rd_ptr and wr_ptr are 1 bit each; buffer states are EMPTY(0), ONE(1) and FULL(2).
- pop = out_valid & out_ready & ~redirect_valid.
- fetch = fetch_en & ~redirect_valid & ((buf_count<2) | pop).
- On fetch:
  - Write {pc, imem_data} at wr_ptr.
  - wr_ptr++ and pc <= pc+1, mod 512 (511 wraps to 0 with no flag).
- On pop: rd_ptr++.
- buf_count' = buf_count + fetch - pop.
  - Fetch and pop in the same cycle while FULL is legal; the count stays at 2.
  - Fetch and pop in the same cycle while EMPTY is impossible, because out_valid=0.
- Latency: an address presented in cycle N appears on out_instr/out_pc in cycle N+1 if the buffer was EMPTY. Steady-state throughput is 1 instruction per cycle while out_ready=1.
- Stall: with out_ready=0 the buffer fills to 2 and fetch stops. pc holds at the next unfetched address. out_instr/out_pc stay stable while out_valid=1 and out_ready=0.
- Redirect (highest priority) at edge N:
  - Buffer flushes: buf_count=0, both pointers reset to 0.
  - pc <= redirect_pc.
  - Nothing is written, and any pop in the same cycle is void.
  - Cycle N+1: imem_addr=redirect_pc, out_valid=0.
  - Cycle N+2: out_valid=1 with out_pc=redirect_pc, provided fetch_en=1.
- Redirect with fetch_en=0: flush and PC load still happen; no fetch follows.
- fetch_en=0: buffered entries still drain via pop; pc frozen.
- out_valid = (buf_count!=0). The head is driven from the entry at rd_ptr. When empty, out_instr and out_pc hold their last value; they are not cleared.
- No X propagation: buffer storage is reset to 0.

Decomposition:
- Shared package gold_core_pkg holds:
  - ADDR_W=9 and INSTR_W=32.
  - The NOP encoding constant.
  - A fetch-entry typedef {pc[0:8], instr[0:31]}, reused by decode.
- One natural sub-module: gold_ibuf.
  - A 2-entry synchronous FIFO with push, pop, flush, count, head.
  - gold_ifetch instantiates it and contains only the PC and control logic.

Test Plan:
- Reset and stream: memory words 0..3 = 0x11111111, 0x22222222, 0x33333333, 0x44444444; release reset; fetch_en=1, out_ready=1.
  - Required: out_valid rises 1 cycle after the first edge.
  - out_pc sequence 0,1,2,3 with matching instructions, one per cycle.
- Backpressure: out_ready=0 from cycle 3.
  - Required: buf_count reaches 2 and pc stops at 4.
  - Head stays at pc 2 until out_ready=1, then 2,3,4 are delivered with no gap or duplicate.
- Redirect with buffer full: buf_count=2, pulse redirect_valid with redirect_pc=0x1F0 and out_ready=1 in the same cycle.
  - Required: no pop counted and buf_count=0 next cycle.
  - imem_addr=0x1F0; two edges later out_pc=0x1F0.
- Wrap-around: redirect to 510 and stream.
  - Required: out_pc sequence 510, 511, 0, 1 with correct data.
- Async reset mid-stream: assert reset_n=0 between edges while buf_count=2.
  - Required: out_valid=0, buf_count=0 and imem_addr=RESET_PC immediately, without waiting for a clock edge.
- fetch_en gating: set fetch_en=0 while buf_count=2 and out_ready=1.
  - Required: two entries drain and out_valid falls.
  - pc unchanged; fetch resumes from that pc when fetch_en=1.
